// File: rtl/planta_pkg.sv
// rtl/planta_pkg.sv - fault codes, operating modes and command decode for the washer plant
package planta_pkg;

    localparam logic [1:0] FALHA_NENHUMA    = 2'd0;
    localparam logic [1:0] FALHA_CONFLITO   = 2'd1;
    localparam logic [1:0] FALHA_MOLHADO    = 2'd2;
    localparam logic [1:0] FALHA_TRANSBORDO = 2'd3;

    typedef enum logic [1:0] {
        ENCHER   = 2'd0,
        SEGURAR  = 2'd1,
        ESVAZIAR = 2'd2,
        CONFLITO = 2'd3
    } modo_e;

    // The drain valve is open by default, so idle and spin both drain the tank.
    function automatic modo_e decodifica_modo(input logic bomba, input logic agitar,
                                              input logic girar, input logic centrifugar);
        logic [2:0] n;
        n = {2'b00, bomba} + {2'b00, agitar} + {2'b00, girar} + {2'b00, centrifugar};
        if (n > 3'd1)
            return CONFLITO;
        else if (bomba)
            return ENCHER;
        else if (agitar || girar)
            return SEGURAR;
        else
            return ESVAZIAR;
    endfunction

endpackage

// File: rtl/planta_lavadora_if.sv
// rtl/planta_lavadora_if.sv - actuator commands and sensor flags between controller and plant
interface planta_lavadora_if #(
    parameter int NIVEL_MAX = 15
);
    localparam int NW = $clog2(NIVEL_MAX + 1);

    logic          bomba_agua;
    logic          modo_agitar;
    logic          modo_girar;
    logic          modo_centrifugar;
    logic [NW-1:0] nivel;
    logic          cheio;
    logic          vazio;
    logic          tempo1;
    logic          tempo2;
    logic          tempo3;
    logic [1:0]    falha;

    modport master (
        output bomba_agua, modo_agitar, modo_girar, modo_centrifugar,
        input  nivel, cheio, vazio, tempo1, tempo2, tempo3, falha
    );

    modport slave (
        input  bomba_agua, modo_agitar, modo_girar, modo_centrifugar,
        output nivel, cheio, vazio, tempo1, tempo2, tempo3, falha
    );

endinterface

// File: rtl/temporizador.sv
// rtl/temporizador.sv - saturating run-time counter, pronto once en has been high for T edges
module temporizador #(
    parameter int T = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic limpa,
    output logic pronto
);
    localparam int CW = $clog2(T + 1);
    localparam logic [CW-1:0] LIMITE = CW'(T);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (limpa || !en)
            count_d = '0;
        else if (count_q != LIMITE)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign pronto = (count_q == LIMITE);

endmodule

// File: rtl/planta_lavadora.sv
// rtl/planta_lavadora.sv - washer plant model: level integrator, mode timers and sticky fault register
module planta_lavadora
    import planta_pkg::*;
#(
    parameter int NIVEL_MAX = 15,
    parameter int PASSO     = 4,
    parameter int T1        = 10,
    parameter int T2        = 8,
    parameter int T3        = 12
) (
    input logic             clock,
    input logic             reset,
    planta_lavadora_if.slave bus
);
    localparam int NW = $clog2(NIVEL_MAX + 1);
    localparam int PW = (PASSO > 1) ? $clog2(PASSO) : 1;
    localparam logic [NW-1:0] NIVEL_CHEIO = NW'(NIVEL_MAX);
    localparam logic [PW-1:0] PASSO_FIM   = PW'(PASSO - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [NW-1:0] nivel_q, nivel_d;
    logic [1:0]    falha_q, falha_d;
    modo_e         modo;
    logic          passo;
    logic          congela;

    assign modo  = decodifica_modo(bus.bomba_agua, bus.modo_agitar,
                                   bus.modo_girar, bus.modo_centrifugar);
    assign passo = (presc_q == PASSO_FIM);

    always_comb begin
        presc_d = passo ? '0 : presc_q + 1'b1;
    end

    // Lowest code wins when several faults coincide; once set, only reset clears it.
    always_comb begin
        falha_d = falha_q;
        if (falha_q == FALHA_NENHUMA) begin
            if (modo == CONFLITO)
                falha_d = FALHA_CONFLITO;
            else if (bus.modo_centrifugar && nivel_q != '0)
                falha_d = FALHA_MOLHADO;
            else if (bus.bomba_agua && passo && nivel_q == NIVEL_CHEIO)
                falha_d = FALHA_TRANSBORDO;
        end
    end

    // Freezing on falha_d keeps the offending step or timer increment from landing.
    assign congela = (falha_d != FALHA_NENHUMA);

    always_comb begin
        nivel_d = nivel_q;
        if (!congela && passo) begin
            if (modo == ENCHER && nivel_q != NIVEL_CHEIO)
                nivel_d = nivel_q + 1'b1;
            else if (modo == ESVAZIAR && nivel_q != '0)
                nivel_d = nivel_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            nivel_q <= '0;
            falha_q <= FALHA_NENHUMA;
        end else begin
            presc_q <= presc_d;
            nivel_q <= nivel_d;
            falha_q <= falha_d;
        end
    end

    temporizador #(.T(T1)) u_tempo_agitar (
        .clock  (clock),
        .reset  (reset),
        .en     (bus.modo_agitar),
        .limpa  (congela),
        .pronto (bus.tempo1)
    );

    temporizador #(.T(T2)) u_tempo_girar (
        .clock  (clock),
        .reset  (reset),
        .en     (bus.modo_girar),
        .limpa  (congela),
        .pronto (bus.tempo2)
    );

    temporizador #(.T(T3)) u_tempo_centrifugar (
        .clock  (clock),
        .reset  (reset),
        .en     (bus.modo_centrifugar),
        .limpa  (congela),
        .pronto (bus.tempo3)
    );

    assign bus.nivel = nivel_q;
    assign bus.cheio = (nivel_q == NIVEL_CHEIO);
    assign bus.vazio = (nivel_q == '0);
    assign bus.falha = falha_q;

endmodule
